// File: rtl/ahb_arb_pkg.sv
// Shared constants and FSM encoding for the AHB bridge front-end arbiter.
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first active request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_M = 2
) (
  input  logic [NUM_M-1:0]         req_i,
  input  logic [$clog2(NUM_M)-1:0] ptr_i,
  output logic [NUM_M-1:0]         gnt_o,
  output logic [$clog2(NUM_M)-1:0] idx_o
);

  localparam int PW = $clog2(NUM_M);

  int   j;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_M; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_M) j = j - NUM_M;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin sharing of one AHB slave port (AHB-to-APB bridge) between NUM_M
// req/done requesters; one NONSEQ single transfer at a time with a data-phase watchdog.
module ahb_bridge_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int TIMEOUT = 16,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic                Hclk,
  input  logic                Hresetn,
  input  logic [NUM_M-1:0]    m_req,
  input  logic [NUM_M-1:0]    m_write,
  input  logic [NUM_M*AW-1:0] m_addr,
  input  logic [NUM_M*DW-1:0] m_wdata,
  output logic [NUM_M-1:0]    m_gnt,
  output logic [NUM_M-1:0]    m_done,
  output logic                m_err,
  output logic [DW-1:0]       m_rdata,
  output logic [AW-1:0]       Haddr,
  output logic                Hwrite,
  output logic [1:0]          Htrans,
  output logic [DW-1:0]       Hwdata,
  output logic                Hreadyin,
  input  logic                Hreadyout,
  input  logic [1:0]          Hresp,
  input  logic [DW-1:0]       Hrdata
);

  localparam int PW = $clog2(NUM_M);
  localparam int TW = $clog2(TIMEOUT) + 1;

  arb_state_t       state_q;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    gidx_q;
  logic [TW-1:0]    timer_q;
  logic [NUM_M-1:0] gnt_q;
  logic [NUM_M-1:0] done_q;
  logic             err_q;
  logic [DW-1:0]    rdata_q;
  logic [AW-1:0]    haddr_q;
  logic             hwrite_q;
  logic [1:0]       htrans_q;
  logic [DW-1:0]    hwdata_q;

  logic [NUM_M-1:0] arb_gnt;
  logic [PW-1:0]    arb_idx;

  rr_arbiter #(.NUM_M(NUM_M)) u_rr (
    .req_i (m_req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      gidx_q   <= '0;
      timer_q  <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      htrans_q <= HTRANS_IDLE;
      hwdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|m_req) begin
            gnt_q    <= arb_gnt;
            gidx_q   <= arb_idx;
            haddr_q  <= m_addr[arb_idx*AW +: AW];
            hwrite_q <= m_write[arb_idx];
            htrans_q <= HTRANS_NONSEQ;
            state_q  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          htrans_q <= HTRANS_IDLE;
          hwdata_q <= m_wdata[gidx_q*DW +: DW];
          timer_q  <= '0;
          state_q  <= ST_DATA;
        end
        ST_DATA: begin
          timer_q <= timer_q + 1'b1;
          // A ready bridge wins over the watchdog when both land on the same edge.
          if (Hreadyout || (timer_q == TW'(TIMEOUT - 1))) begin
            if (Hreadyout) begin
              if (!hwrite_q) rdata_q <= Hrdata;
              err_q <= (Hresp != HRESP_OKAY);
            end else begin
              err_q <= 1'b1;
            end
            done_q  <= gnt_q;
            gnt_q   <= '0;
            ptr_q   <= (gidx_q == PW'(NUM_M - 1)) ? '0 : gidx_q + 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= '0;
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Hreadyin = (state_q == ST_DATA) ? Hreadyout : 1'b1;

  assign m_gnt   = gnt_q;
  assign m_done  = done_q;
  assign m_err   = err_q;
  assign m_rdata = rdata_q;
  assign Haddr   = haddr_q;
  assign Hwrite  = hwrite_q;
  assign Htrans  = htrans_q;
  assign Hwdata  = hwdata_q;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Bench for ahb_bridge_arbiter: directed vector table, reset corner cases and
// randomized transfers checked against a transaction-level round-robin model.
module tb_ahb_bridge_arbiter;

  localparam int NUM_M   = 2;
  localparam int TIMEOUT = 16;
  localparam int AW      = 32;
  localparam int DW      = 32;

  logic                Hclk = 1'b0;
  logic                Hresetn;
  logic [NUM_M-1:0]    m_req;
  logic [NUM_M-1:0]    m_write;
  logic [NUM_M*AW-1:0] m_addr;
  logic [NUM_M*DW-1:0] m_wdata;
  logic [NUM_M-1:0]    m_gnt;
  logic [NUM_M-1:0]    m_done;
  logic                m_err;
  logic [DW-1:0]       m_rdata;
  logic [AW-1:0]       Haddr;
  logic                Hwrite;
  logic [1:0]          Htrans;
  logic [DW-1:0]       Hwdata;
  logic                Hreadyin;
  logic                Hreadyout;
  logic [1:0]          Hresp;
  logic [DW-1:0]       Hrdata;

  ahb_bridge_arbiter #(.NUM_M(NUM_M), .TIMEOUT(TIMEOUT), .AW(AW), .DW(DW)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn),
    .m_req(m_req), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_done(m_done), .m_err(m_err), .m_rdata(m_rdata),
    .Haddr(Haddr), .Hwrite(Hwrite), .Htrans(Htrans), .Hwdata(Hwdata),
    .Hreadyin(Hreadyin), .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata)
  );

  always #5 Hclk = ~Hclk;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [31:0] a0, a1, d0, d1;
    int          waits;
    logic [1:0]  resp;
    logic [31:0] hrdata;
    bit          drop;
    int          exp_g;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  int          nvec = 0;
  int          nfail = 0;
  int          ptr_m = 0;
  logic [31:0] rdata_m = '0;
  vec_t        tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] req, input logic [1:0] wr,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input int waits, input logic [1:0] resp,
                              input logic [31:0] hrdata, input bit drop,
                              input int g, input bit err, input logic [31:0] rd);
    vec_t v;
    v.req = req; v.wr = wr; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.waits = waits; v.resp = resp; v.hrdata = hrdata; v.drop = drop;
    v.exp_g = g; v.exp_err = err; v.exp_rdata = rd;
    return v;
  endfunction

  // Round-robin reference: first requester at or after the pointer, wrapping.
  function automatic int winner(input logic [1:0] req, input int p);
    for (int k = 0; k < NUM_M; k++) begin
      if (req[(p + k) % NUM_M]) return (p + k) % NUM_M;
    end
    return 0;
  endfunction

  // Entered and left at a falling edge with the arbiter idle.
  task automatic run_xfer(input vec_t v);
    int          c;
    int          cexp;
    int          g;
    logic [31:0] ea;
    logic [31:0] ed;
    g  = v.exp_g;
    ea = (g != 0) ? v.a1 : v.a0;
    ed = (g != 0) ? v.d1 : v.d0;
    m_req = v.req; m_write = v.wr; m_addr = {v.a1, v.a0}; m_wdata = {v.d1, v.d0};
    Hreadyout = 1'b1; Hresp = 2'b00;
    @(posedge Hclk); @(negedge Hclk);
    chk("gnt_addr", m_gnt, 64'(1 << g));
    chk("htrans_addr", Htrans, 2'b10);
    chk("haddr", Haddr, ea);
    chk("hwrite", Hwrite, v.wr[g]);
    chk("hreadyin_addr", Hreadyin, 1'b1);
    if (v.drop) m_req = '0;
    @(posedge Hclk); @(negedge Hclk);
    chk("htrans_data", Htrans, 2'b00);
    chk("hwdata", Hwdata, ed);
    chk("gnt_data", m_gnt, 64'(1 << g));
    c = 0;
    while (1) begin
      if (c >= v.waits) begin
        Hreadyout = 1'b1; Hresp = v.resp; Hrdata = v.hrdata;
      end else begin
        Hreadyout = 1'b0; Hresp = 2'($urandom_range(0, 3)); Hrdata = 32'hBAD0_0000 + c;
      end
      #1;
      chk("hreadyin_data", Hreadyin, Hreadyout);
      @(posedge Hclk); @(negedge Hclk);
      if (m_done != '0 || c > TIMEOUT + 2) break;
      c++;
    end
    cexp = (v.waits < TIMEOUT) ? v.waits : TIMEOUT - 1;
    chk("done_cycle", c, cexp);
    chk("m_done", m_done, 64'(1 << g));
    chk("m_err", m_err, v.exp_err);
    chk("m_rdata", m_rdata, v.exp_rdata);
    chk("gnt_cleared", m_gnt, 0);
    chk("haddr_hold", Haddr, ea);
    Hreadyout = 1'b1; Hresp = 2'b00;
    @(posedge Hclk); @(negedge Hclk);
    chk("done_pulse", m_done, 0);
    chk("err_pulse", m_err, 0);
    chk("gnt_idle", m_gnt, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench watchdog");
  end

  initial begin
    vec_t v;
    tbl[0] = mk(2'b01, 2'b01, 32'h10,  32'h0,   32'hA5A5A5A5, 32'h0, 0,  2'b00, 32'h0,        0, 0, 0, 32'h0);
    tbl[1] = mk(2'b10, 2'b00, 32'h0,   32'h20,  32'h0,        32'h0, 2,  2'b00, 32'hDEADBEEF, 0, 1, 0, 32'hDEADBEEF);
    tbl[2] = mk(2'b11, 2'b10, 32'h100, 32'h104, 32'h1,        32'h2, 1,  2'b00, 32'h11111111, 0, 0, 0, 32'h11111111);
    tbl[3] = mk(2'b11, 2'b10, 32'h100, 32'h104, 32'h1,        32'h2, 0,  2'b00, 32'h55555555, 0, 1, 0, 32'h11111111);
    tbl[4] = mk(2'b11, 2'b10, 32'h100, 32'h104, 32'h1,        32'h2, 0,  2'b01, 32'h22222222, 0, 0, 1, 32'h22222222);
    tbl[5] = mk(2'b11, 2'b10, 32'h100, 32'h104, 32'h1,        32'h2, 3,  2'b00, 32'h77777777, 0, 1, 0, 32'h22222222);
    tbl[6] = mk(2'b01, 2'b00, 32'h30,  32'h34,  32'h3,        32'h4, 15, 2'b00, 32'h33333333, 0, 0, 0, 32'h33333333);
    tbl[7] = mk(2'b11, 2'b00, 32'h30,  32'h34,  32'h3,        32'h4, 20, 2'b00, 32'h66666666, 0, 1, 1, 32'h33333333);
    tbl[8] = mk(2'b10, 2'b10, 32'h50,  32'h54,  32'h5,        32'h6, 3,  2'b00, 32'h88888888, 1, 1, 0, 32'h33333333);
    tbl[9] = mk(2'b11, 2'b00, 32'h60,  32'h64,  32'h7,        32'h8, 0,  2'b11, 32'h44444444, 0, 0, 1, 32'h44444444);

    // Reset held three cycles with both requesters active.
    Hresetn = 1'b0; m_req = 2'b11; m_write = 2'b11;
    m_addr = {32'h1234, 32'h5678}; m_wdata = {32'hFFFF0000, 32'h0000FFFF};
    Hreadyout = 1'b1; Hresp = 2'b00; Hrdata = 32'hCAFEF00D;
    repeat (3) @(posedge Hclk);
    @(negedge Hclk);
    chk("rst_gnt", m_gnt, 0);
    chk("rst_done", m_done, 0);
    chk("rst_err", m_err, 0);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_haddr", Haddr, 0);
    chk("rst_hwrite", Hwrite, 0);
    chk("rst_htrans", Htrans, 0);
    chk("rst_hwdata", Hwdata, 0);
    chk("rst_hreadyin", Hreadyin, 1'b1);
    m_req = '0; Hresetn = 1'b1;
    @(posedge Hclk); @(negedge Hclk);
    chk("idle_no_req", m_gnt, 0);

    for (int i = 0; i < 10; i++) begin
      run_xfer(tbl[i]);
      ptr_m   = (tbl[i].exp_g + 1) % NUM_M;
      rdata_m = tbl[i].exp_rdata;
    end

    // Reset while the bridge is stalling the data phase.
    m_req = 2'b01; m_write = 2'b00; m_addr = {32'h44, 32'h40};
    @(posedge Hclk); @(negedge Hclk);
    @(posedge Hclk); @(negedge Hclk);
    Hreadyout = 1'b0;
    @(posedge Hclk); @(negedge Hclk);
    Hresetn = 1'b0;
    @(posedge Hclk); @(negedge Hclk);
    chk("mid_rst_done", m_done, 0);
    chk("mid_rst_gnt", m_gnt, 0);
    chk("mid_rst_htrans", Htrans, 0);
    chk("mid_rst_haddr", Haddr, 0);
    chk("mid_rst_rdata", m_rdata, 0);
    chk("mid_rst_hreadyin", Hreadyin, 1'b1);
    m_req = '0; Hresetn = 1'b1; Hreadyout = 1'b1;
    @(posedge Hclk); @(negedge Hclk);
    chk("post_rst_done", m_done, 0);
    ptr_m = 0; rdata_m = '0;

    // Randomized transfers against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      v.req    = 2'($urandom_range(1, 3));
      v.wr     = 2'($urandom_range(0, 3));
      v.a0     = $urandom; v.a1 = $urandom; v.d0 = $urandom; v.d1 = $urandom;
      v.waits  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 4));
      v.resp   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      v.hrdata = $urandom;
      v.drop   = 1'($urandom_range(0, 1));
      v.exp_g  = winner(v.req, ptr_m);
      v.exp_err = (v.waits >= TIMEOUT) || (v.resp != 2'b00);
      v.exp_rdata = (!v.wr[v.exp_g] && v.waits < TIMEOUT) ? v.hrdata : rdata_m;
      run_xfer(v);
      ptr_m   = (v.exp_g + 1) % NUM_M;
      rdata_m = v.exp_rdata;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
